// File: rtl/timer_if.sv
// Bridge-side bus bundle for the countdown timer: word address, write strobe/data, read data and IRQ.
interface timer_if;
    localparam int unsigned W = 32;

    logic [W-1:0] Addr;
    logic         WE;
    logic [W-1:0] Din;
    logic [W-1:0] Dout;
    logic         IRQ;

    modport master (output Addr, WE, Din, input Dout, IRQ);
    modport slave  (input Addr, WE, Din, output Dout, IRQ);
endinterface

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer (CTRL/PRESET/COUNT) raising an interrupt request to CP0.
// Optional feature macro: TIMER_AUTO_RELOAD_EN enables MODE=01 auto-reload; otherwise every mode is one-shot.
module timer_dev (
    input  logic   clk,
    input  logic   RESET,
    timer_if.slave bus
);
    localparam int unsigned W      = 32;
    localparam int unsigned CTRL_W = 4;

    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    state_t            state;
    logic [CTRL_W-1:0] ctrl;
    logic [W-1:0]      preset;
    logic [W-1:0]      count;
    logic              irq_flag;

    logic wr_ctrl;
    logic wr_preset;
    logic auto_reload;
    logic unused_addr;

    assign wr_ctrl     = bus.WE && (bus.Addr[3:2] == 2'b00);
    assign wr_preset   = bus.WE && (bus.Addr[3:2] == 2'b01);
    assign unused_addr = ^{bus.Addr[W-1:4], bus.Addr[1:0]};

`ifdef TIMER_AUTO_RELOAD_EN
    assign auto_reload = (ctrl[2:1] == 2'b01);
`else
    assign auto_reload = 1'b0;
`endif

    // FSM and register file; bus writes are applied last so they win over FSM updates
    always_ff @(posedge clk) begin
        if (RESET) begin
            state    <= IDLE;
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ctrl[0]) state <= LOAD;
                end
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!ctrl[0]) begin
                        state <= IDLE;
                    end else if (count > W'(1)) begin
                        count <= count - W'(1);
                    end else begin
                        count    <= '0;
                        irq_flag <= 1'b1;
                        state    <= INT;
                    end
                end
                INT: begin
                    state <= IDLE;
                    if (auto_reload) irq_flag <= 1'b0;
                    else             ctrl[0]  <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            if (wr_ctrl) begin
                ctrl     <= bus.Din[CTRL_W-1:0];
                irq_flag <= 1'b0;
            end
            if (wr_preset) begin
                preset   <= bus.Din;
                irq_flag <= 1'b0;
            end
        end
    end

    // zero-latency read mux
    always_comb begin
        bus.Dout = '0;
        case (bus.Addr[3:2])
            2'b00:   bus.Dout = {{(W-CTRL_W){1'b0}}, ctrl};
            2'b01:   bus.Dout = preset;
            2'b10:   bus.Dout = count;
            default: bus.Dout = '0;
        endcase
    end

    assign bus.IRQ = irq_flag & ctrl[3];
endmodule

// File: tb/tb_timer_dev.sv
// Bench for timer_dev: vector table, directed corner sequences and random traffic against a cycle-position model.
module tb_timer_dev;
    logic clk;
    logic RESET;

    timer_if bus();

    timer_dev dut (
        .clk  (clk),
        .RESET(RESET),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    string phase = "init";

    // Model: timer position -1 idle, 0 load, 1..len counting, len+1 interrupt
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic [31:0] m_lat;
    logic        m_flag;
    longint      m_pos;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] din;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [31:0] a, input logic we, input logic [31:0] d,
                       input logic [31:0] ed, input logic ei);
        vec_t v;
        v.addr = a; v.we = we; v.din = d; v.exp_dout = ed; v.exp_irq = ei;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%s]: got %h, expected %h", name, phase, act, exp);
        end
    endtask

    function automatic logic [31:0] m_dout(input logic [31:0] a);
        case (a[3:2])
            2'b00:   return {28'b0, m_ctrl};
            2'b01:   return m_preset;
            2'b10:   return m_count;
            default: return 32'b0;
        endcase
    endfunction

    task automatic model_edge(input logic [31:0] a, input logic we, input logic [31:0] d,
                              input logic rst);
        logic [3:0]  n_ctrl;
        logic [31:0] n_pre;
        logic [31:0] n_cnt;
        logic [31:0] n_lat;
        logic        n_flag;
        longint      n_pos;
        longint      len;
        logic        en;
        logic        auto_m;
        if (rst) begin
            m_ctrl = '0; m_preset = '0; m_count = '0; m_lat = '0; m_flag = 1'b0; m_pos = -1;
        end else begin
            n_ctrl = m_ctrl; n_pre = m_preset; n_cnt = m_count; n_lat = m_lat;
            n_flag = m_flag; n_pos = m_pos;
            en = m_ctrl[0];
`ifdef TIMER_AUTO_RELOAD_EN
            auto_m = (m_ctrl[2:1] == 2'b01);
`else
            auto_m = 1'b0;
`endif
            len = (m_lat == 32'd0) ? 64'sd1 : longint'({32'b0, m_lat});
            if (m_pos < 0) begin
                if (en) n_pos = 0;
            end else if (m_pos == 0) begin
                n_lat = m_preset; n_cnt = m_preset; n_pos = 1;
            end else if (m_pos <= len) begin
                if (!en) n_pos = -1;
                else if (m_pos < len) begin
                    n_pos = m_pos + 1;
                    n_cnt = m_lat - 32'(m_pos);
                end else begin
                    n_pos = len + 1; n_cnt = '0; n_flag = 1'b1;
                end
            end else begin
                n_pos = -1;
                if (auto_m) n_flag = 1'b0;
                else        n_ctrl[0] = 1'b0;
            end
            if (we && a[3:2] == 2'b00) begin n_ctrl = d[3:0]; n_flag = 1'b0; end
            if (we && a[3:2] == 2'b01) begin n_pre  = d;      n_flag = 1'b0; end
            m_ctrl = n_ctrl; m_preset = n_pre; m_count = n_cnt; m_lat = n_lat;
            m_flag = n_flag; m_pos = n_pos;
        end
    endtask

    // One bus cycle: drive, clock, advance model, compare against the model
    task automatic cycle(input logic [31:0] a, input logic we, input logic [31:0] d);
        bus.Addr = a; bus.WE = we; bus.Din = d;
        @(posedge clk);
        model_edge(a, we, d, RESET);
        #1;
        check("model_dout", bus.Dout, m_dout(a));
        check("model_irq", {31'b0, bus.IRQ}, {31'b0, m_flag & m_ctrl[3]});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic        found;
        logic        exp_irq;
        logic [31:0] r;
        logic [1:0]  sel;
        logic        we;
        logic [31:0] a;
        logic [31:0] d;

        RESET = 1'b1;
        bus.Addr = '0; bus.WE = 1'b0; bus.Din = '0;
        m_ctrl = '0; m_preset = '0; m_count = '0; m_lat = '0; m_flag = 1'b0; m_pos = -1;

        // reset reads, one-shot P=5, one-shot P=0, ignored writes
        add(32'h0, 0, 0, 0, 0); add(32'h4, 0, 0, 0, 0); add(32'h8, 0, 0, 0, 0); add(32'hC, 0, 0, 0, 0);
        add(32'h4, 1, 5, 5, 0); add(32'h0, 1, 9, 9, 0);
        add(32'h8, 0, 0, 0, 0); add(32'h8, 0, 0, 5, 0); add(32'h8, 0, 0, 4, 0); add(32'h8, 0, 0, 3, 0);
        add(32'h8, 0, 0, 2, 0); add(32'h8, 0, 0, 1, 0); add(32'h8, 0, 0, 0, 1);
        add(32'h0, 0, 0, 8, 1); add(32'h0, 0, 0, 8, 1); add(32'h0, 1, 0, 0, 0);
        add(32'h4, 1, 0, 0, 0); add(32'h0, 1, 9, 9, 0);
        add(32'h8, 0, 0, 0, 0); add(32'h8, 0, 0, 0, 0); add(32'h8, 0, 0, 0, 1);
        add(32'h0, 0, 0, 8, 1); add(32'h0, 1, 0, 0, 0);
        add(32'h8, 1, 32'h1234, 0, 0); add(32'hC, 1, 32'hFFFF, 0, 0);
        add(32'h4, 0, 0, 0, 0); add(32'h0, 0, 0, 0, 0);

        phase = "reset";
        cycle(32'h0, 0, 0);
        cycle(32'h0, 0, 0);
        RESET = 1'b0;

        phase = "table";
        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].addr, vecs[i].we, vecs[i].din);
            check($sformatf("vec%0d_dout", i), bus.Dout, vecs[i].exp_dout);
            check($sformatf("vec%0d_irq", i), {31'b0, bus.IRQ}, {31'b0, vecs[i].exp_irq});
        end

        phase = "auto_reload";
        cycle(32'h4, 1, 3);
        cycle(32'h0, 1, 32'hB);
        for (int k = 1; k <= 24; k++) begin
            cycle(32'h8, 0, 0);
`ifdef TIMER_AUTO_RELOAD_EN
            exp_irq = (k >= 5) && ((k - 5) % 6 == 0);
`else
            exp_irq = (k >= 5);
`endif
            check($sformatf("ar_irq_k%0d", k), {31'b0, bus.IRQ}, {31'b0, exp_irq});
        end
        cycle(32'h0, 0, 0);
`ifdef TIMER_AUTO_RELOAD_EN
        check("ar_ctrl", bus.Dout, 32'hB);
`else
        check("ar_ctrl", bus.Dout, 32'hA);
`endif
        cycle(32'h0, 1, 0);
        check("ar_stop_irq", {31'b0, bus.IRQ}, 32'h0);
        for (int k = 0; k < 4; k++) cycle(32'h0, 0, 0);

        phase = "disable";
        cycle(32'h4, 1, 10);
        cycle(32'h0, 1, 1);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle(32'h8, 0, 0);
            if (bus.Dout == 32'd6) found = 1'b1;
        end
        check("dis_wait_count6", {31'b0, found}, 32'h1);
        cycle(32'h0, 1, 0);
        for (int k = 0; k < 4; k++) begin
            cycle(32'h8, 0, 0);
            check($sformatf("dis_frozen_%0d", k), bus.Dout, 32'd5);
            check($sformatf("dis_irq_%0d", k), {31'b0, bus.IRQ}, 32'h0);
        end
        cycle(32'h8, 1, 99);
        check("count_write_ignored", bus.Dout, 32'd5);

        phase = "masked";
        cycle(32'h4, 1, 2);
        cycle(32'h0, 1, 1);
        for (int k = 0; k < 6; k++) begin
            cycle(32'h8, 0, 0);
            check($sformatf("mask_irq_%0d", k), {31'b0, bus.IRQ}, 32'h0);
        end
        cycle(32'h0, 1, 8);
        check("mask_im_set_irq", {31'b0, bus.IRQ}, 32'h0);
        cycle(32'h0, 0, 0);
        check("mask_ctrl", bus.Dout, 32'h8);
        check("mask_im_set_irq2", {31'b0, bus.IRQ}, 32'h0);
        cycle(32'h0, 1, 0);

        phase = "collision";
        cycle(32'h4, 1, 4);
        cycle(32'h0, 1, 9);
        for (int k = 0; k < 5; k++) cycle(32'h8, 0, 0);
        check("col_count1", bus.Dout, 32'd1);
        cycle(32'h4, 1, 4);
        check("col_irq_int", {31'b0, bus.IRQ}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            cycle(32'h0, 0, 0);
            check($sformatf("col_irq_%0d", k), {31'b0, bus.IRQ}, 32'h0);
        end
        check("col_ctrl", bus.Dout, 32'h8);
        cycle(32'h0, 1, 0);

        phase = "reset_mid";
        cycle(32'h4, 1, 20);
        cycle(32'h0, 1, 9);
        for (int k = 0; k < 5; k++) cycle(32'h8, 0, 0);
        RESET = 1'b1;
        cycle(32'h8, 0, 0);
        check("rst_count", bus.Dout, 32'h0);
        RESET = 1'b0;
        cycle(32'h0, 0, 0);
        check("rst_ctrl", bus.Dout, 32'h0);
        cycle(32'h4, 0, 0);
        check("rst_preset", bus.Dout, 32'h0);
        cycle(32'h8, 0, 0);
        check("rst_count2", bus.Dout, 32'h0);
        check("rst_irq", {31'b0, bus.IRQ}, 32'h0);

        phase = "random";
        for (int k = 0; k < 400; k++) begin
            RESET = ($urandom_range(0, 99) == 0);
            r   = $urandom();
            sel = 2'($urandom_range(0, 3));
            a   = {r[31:4], sel, r[1:0]};
            we  = !RESET && ($urandom_range(0, 3) == 0);
            d   = (sel == 2'b01) ? 32'($urandom_range(0, 6)) : $urandom();
            cycle(a, we, d);
        end
        RESET = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
